// File: rtl/disparity_readout.sv
// Reader for the stereo disparity result BRAM. After the matcher's frame-done
// pulse it takes the BRAM port, sweeps addresses row-major and streams scaled
// pixels out over valid/ready with end-of-line / end-of-frame tags. Read
// latency is absorbed by a small FIFO whose free space is tracked as credits.
module disparity_readout #(
  parameter int IMG_W       = 240,
  parameter int IMG_H       = 320,
  parameter int ADDR_W      = 17,
  parameter int RD_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int SCALE_SHIFT = 0
) (
  input  logic              clk_100mhz,
  input  logic              sys_rst_n,
  input  logic              frame_done_in,
  output logic              reading_out,
  output logic [ADDR_W-1:0] ssd_addr_out,
  input  logic [7:0]        ssd_dout_in,
  output logic [7:0]        px_data_out,
  output logic              px_valid_out,
  input  logic              px_ready_in,
  output logic              px_eol_out,
  output logic              px_last_out,
  output logic              busy_out,
  output logic              overrun_out
);

  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 2);
  localparam int ENT_W = 10;  // {last, eol, data[7:0]}

  localparam logic [XW-1:0]    X_MAX    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]    Y_MAX    = YW'(IMG_H - 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Left shift with saturation to the 8-bit pixel range.
  function automatic logic [7:0] scale_px(input logic [7:0] din);
    logic [15:0] tmp;
    tmp = {8'd0, din} << SCALE_SHIFT;
    if (tmp > 16'd255) begin
      scale_px = 8'd255;
    end else begin
      scale_px = tmp[7:0];
    end
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_MAX) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  state_t                  state_r, state_s;
  logic                    pending_r, pending_s, overrun_r, overrun_s;
  logic                    reading_r, busy_r, start_s;
  logic [XW-1:0]           x_r;
  logic [YW-1:0]           y_r;
  logic [ADDR_W-1:0]       addr_cnt_r, ssd_addr_r;
  logic                    iss_vld_r, iss_eol_r, iss_last_r;
  logic [RD_LATENCY-1:0]   dly_vld_r, dly_eol_r, dly_last_r;
  logic [ENT_W-1:0]        fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]        fifo_cnt_r, inflight_s;
  logic                    issue_s, push_s, pop_s, x_last_s, frame_last_s, drained_s;

  // Credit accounting and handshake decode from registered state only.
  always_comb begin
    inflight_s = CNT_W'(iss_vld_r);
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_s = inflight_s + CNT_W'(dly_vld_r[i]);
    end
    issue_s      = (state_r == ST_STREAM) && ((fifo_cnt_r + inflight_s) < CNT_CAP);
    push_s       = dly_vld_r[RD_LATENCY-1];
    pop_s        = (fifo_cnt_r != CNT_ZERO) && px_ready_in;
    x_last_s     = (x_r == X_MAX);
    frame_last_s = x_last_s && (y_r == Y_MAX);
    drained_s    = (inflight_s == CNT_ZERO) &&
                   ((fifo_cnt_r == CNT_ZERO) || ((fifo_cnt_r == CNT_ONE) && pop_s));
  end

  // Next-state, frame queueing and overrun detection.
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    pending_s = pending_r;
    overrun_s = overrun_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_done_in) begin
          state_s = ST_STREAM;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (issue_s && frame_last_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (drained_s) begin
          // A pulse landing on the final transfer is treated as a queued frame.
          if (pending_r || frame_done_in) begin
            state_s = ST_STREAM;
            start_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (start_s) begin
      pending_s = 1'b0;
    end else begin
      pending_s = pending_r;
    end
    if ((state_r != ST_IDLE) && frame_done_in) begin
      if (pending_r) begin
        overrun_s = 1'b1;
      end else if (!start_s) begin
        pending_s = 1'b1;
      end else begin
        pending_s = 1'b0;
      end
    end else begin
      overrun_s = overrun_r;
    end
  end

  // Control state register; port ownership follows the next state.
  always_ff @(posedge clk_100mhz) begin
    if (!sys_rst_n) begin
      state_r   <= ST_IDLE;
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
      reading_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      pending_r <= pending_s;
      overrun_r <= overrun_s;
      reading_r <= (state_s != ST_IDLE);
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  // Raster counters and address issue; the address port holds between issues.
  always_ff @(posedge clk_100mhz) begin
    if (!sys_rst_n) begin
      x_r        <= {XW{1'b0}};
      y_r        <= {YW{1'b0}};
      addr_cnt_r <= {ADDR_W{1'b0}};
      ssd_addr_r <= {ADDR_W{1'b0}};
    end else if (start_s) begin
      x_r        <= {XW{1'b0}};
      y_r        <= {YW{1'b0}};
      addr_cnt_r <= {ADDR_W{1'b0}};
    end else if (issue_s) begin
      ssd_addr_r <= addr_cnt_r;
      addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
      if (x_last_s) begin
        x_r <= {XW{1'b0}};
        y_r <= y_r + YW'(1);
      end else begin
        x_r <= x_r + XW'(1);
      end
    end else begin
      ssd_addr_r <= ssd_addr_r;
    end
  end

  // Issue flag with tags, then a RD_LATENCY-deep delay line marking read return.
  always_ff @(posedge clk_100mhz) begin
    if (!sys_rst_n) begin
      iss_vld_r  <= 1'b0;
      iss_eol_r  <= 1'b0;
      iss_last_r <= 1'b0;
      dly_vld_r  <= {RD_LATENCY{1'b0}};
      dly_eol_r  <= {RD_LATENCY{1'b0}};
      dly_last_r <= {RD_LATENCY{1'b0}};
    end else begin
      iss_vld_r     <= issue_s;
      iss_eol_r     <= x_last_s;
      iss_last_r    <= frame_last_s;
      dly_vld_r[0]  <= iss_vld_r;
      dly_eol_r[0]  <= iss_eol_r;
      dly_last_r[0] <= iss_last_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        dly_vld_r[i]  <= dly_vld_r[i-1];
        dly_eol_r[i]  <= dly_eol_r[i-1];
        dly_last_r[i] <= dly_last_r[i-1];
      end
    end
  end

  // Skid FIFO: storage is cleared on reset so the head reads zero when empty.
  always_ff @(posedge clk_100mhz) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {ENT_W{1'b0}};
      end
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {dly_last_r[RD_LATENCY-1], dly_eol_r[RD_LATENCY-1],
                                 scale_px(ssd_dout_in)};
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  assign reading_out  = reading_r;
  assign busy_out     = busy_r;
  assign overrun_out  = overrun_r;
  assign ssd_addr_out = ssd_addr_r;
  assign px_valid_out = (fifo_cnt_r != CNT_ZERO);
  assign px_data_out  = fifo_mem_r[rd_ptr_r][7:0];
  assign px_eol_out   = fifo_mem_r[rd_ptr_r][8];
  assign px_last_out  = fifo_mem_r[rd_ptr_r][9];

endmodule

// File: tb/tb_disparity_readout.sv
// Directed-plus-random bench for disparity_readout on a reduced 8x6 image.
// Two instances share clock, reset, frame_done and ready: one unscaled, one
// with SCALE_SHIFT=2. Expected pixels come from the frame contents in raster order.
module tb_disparity_readout;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = W * H;
  localparam int AW   = 6;

  logic          clk;
  logic          rst_n;
  logic          frame_done;
  logic          px_ready;
  logic          reading_a, valid_a, eol_a, last_a, busy_a, ovr_a;
  logic [AW-1:0] addr_a;
  logic [7:0]    data_a, dout_a, q1_a;
  logic          reading_b, valid_b, eol_b, last_b, busy_b, ovr_b;
  logic [AW-1:0] addr_b;
  logic [7:0]    data_b, dout_b, q1_b;

  logic [7:0]    mem_a [0:63];
  logic [7:0]    mem_b [0:63];
  logic [9:0]    exp_q [$];
  logic [7:0]    expb_q [$];
  int            total, bad;
  bit            prev_stall, chk_b;
  logic [9:0]    held;

  disparity_readout #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LATENCY(2),
                      .FIFO_DEPTH(4), .SCALE_SHIFT(0)) u_dut (
    .clk_100mhz(clk), .sys_rst_n(rst_n), .frame_done_in(frame_done),
    .reading_out(reading_a), .ssd_addr_out(addr_a), .ssd_dout_in(dout_a),
    .px_data_out(data_a), .px_valid_out(valid_a), .px_ready_in(px_ready),
    .px_eol_out(eol_a), .px_last_out(last_a), .busy_out(busy_a), .overrun_out(ovr_a));

  disparity_readout #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LATENCY(2),
                      .FIFO_DEPTH(4), .SCALE_SHIFT(2)) u_dut_b (
    .clk_100mhz(clk), .sys_rst_n(rst_n), .frame_done_in(frame_done),
    .reading_out(reading_b), .ssd_addr_out(addr_b), .ssd_dout_in(dout_b),
    .px_data_out(data_b), .px_valid_out(valid_b), .px_ready_in(px_ready),
    .px_eol_out(eol_b), .px_last_out(last_b), .busy_out(busy_b), .overrun_out(ovr_b));

  always #5 clk = ~clk;

  // Two-cycle BRAM models: data appears two edges after the address.
  always @(posedge clk) begin
    q1_a   <= mem_a[addr_a];
    dout_a <= q1_a;
    q1_b   <= mem_b[addr_b];
    dout_b <= q1_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_frame_a();
    for (int k = 0; k < NPIX; k++) begin
      exp_q.push_back({(k == NPIX - 1), ((k % W) == W - 1), mem_a[k]});
    end
  endtask

  // One clock: drive inputs, check the transfer (if any) at the falling edge.
  task automatic cycle(input bit rdy, input bit fd);
    logic [9:0] e;
    px_ready   = rdy;
    frame_done = fd;
    @(negedge clk);
    if (prev_stall) begin
      chk("stall_valid", 32'(valid_a), 32'd1);
      chk("stall_hold", 32'({last_a, eol_a, data_a}), 32'(held));
    end
    if (valid_a && px_ready) begin
      chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("px_data", 32'(data_a), 32'(e[7:0]));
        chk("px_eol", 32'(eol_a), 32'(e[8]));
        chk("px_last", 32'(last_a), 32'(e[9]));
      end
    end
    prev_stall = valid_a && !px_ready;
    held       = {last_a, eol_a, data_a};
    if (chk_b && valid_b && px_ready) begin
      chk("b_queue_nonempty", 32'(expb_q.size() != 0), 32'd1);
      if (expb_q.size() != 0) begin
        chk("b_scaled", 32'(data_b), 32'(expb_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    frame_done = 1'b0;
  endtask

  task automatic run_until_empty(input bit rand_ready, input int limit, input string tag);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || expb_q.size() != 0) && guard < limit) begin
      cycle(rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      guard++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_reading"}, 32'(reading_a), 32'd0);
    chk({tag, "_addr"}, 32'(addr_a), 32'd0);
    chk({tag, "_data"}, 32'(data_a), 32'd0);
    chk({tag, "_valid"}, 32'(valid_a), 32'd0);
    chk({tag, "_eol"}, 32'(eol_a), 32'd0);
    chk({tag, "_last"}, 32'(last_a), 32'd0);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_overrun"}, 32'(ovr_a), 32'd0);
  endtask

  initial begin
    int i;
    total = 0; bad = 0; prev_stall = 1'b0; chk_b = 1'b0; held = 10'd0;
    clk = 1'b0; rst_n = 1'b0; frame_done = 1'b0; px_ready = 1'b0;
    for (int k = 0; k < 64; k++) begin
      mem_a[k] = 8'(k);
      mem_b[k] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    cycle(1'b1, 1'b0);

    // 1: address pattern, ready always high, first-valid latency and tags.
    push_frame_a();
    cycle(1'b1, 1'b1);
    chk("t1_reading", 32'(reading_a), 32'd1);
    chk("t1_busy", 32'(busy_a), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, 1'b0);
      chk("t1_first_valid", 32'(valid_a), 32'(k == 4));
    end
    run_until_empty(1'b0, 400, "t1");
    chk("t1_reading_off", 32'(reading_a), 32'd0);
    chk("t1_busy_off", 32'(busy_a), 32'd0);

    // 2: random data, random backpressure.
    for (int k = 0; k < NPIX; k++) mem_a[k] = 8'($urandom_range(0, 255));
    push_frame_a();
    cycle(1'($urandom_range(0, 1)), 1'b1);
    run_until_empty(1'b1, 1000, "t2");
    chk("t2_reading_off", 32'(reading_a), 32'd0);

    // 3: ready held low -> only four addresses go out, FIFO fills.
    for (int k = 0; k < NPIX; k++) mem_a[k] = 8'(k * 3 + 1);
    push_frame_a();
    cycle(1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b0);
    chk("t3_addr_stalled", 32'(addr_a), 32'd3);
    chk("t3_head_valid", 32'(valid_a), 32'd1);
    chk("t3_head_data", 32'(data_a), 32'(mem_a[0]));
    run_until_empty(1'b0, 400, "t3");

    // 4: second pulse queues a frame, third pulse flags overrun.
    push_frame_a();
    push_frame_a();
    cycle(1'b1, 1'b1);
    i = 0;
    while (exp_q.size() != 0 && i < 800) begin
      cycle(1'b1, (i == 10) || (i == 20));
      i++;
    end
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_overrun", 32'(ovr_a), 32'd1);
    repeat (20) cycle(1'b1, 1'b0);
    chk("t4_idle", 32'(reading_a), 32'd0);
    chk("t4_overrun_sticky", 32'(ovr_a), 32'd1);

    // 5: reset mid-frame, then a clean restart.
    push_frame_a();
    cycle(1'b1, 1'b1);
    i = 0;
    while ((NPIX - exp_q.size()) < 20 && i < 400) begin
      cycle(1'b1, 1'b0);
      i++;
    end
    chk("t5_reached_px20", 32'(NPIX - exp_q.size()), 32'd20);
    rst_n = 1'b0;
    cycle(1'b1, 1'b0);
    chk_all_zero("t5_midreset");
    rst_n = 1'b1;
    exp_q.delete();
    prev_stall = 1'b0;
    push_frame_a();
    cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b1, 1'b0);
    chk("t5_restart_addr", 32'(addr_a), 32'd2);
    run_until_empty(1'b0, 400, "t5");

    // 6: SCALE_SHIFT=2 instance, including saturation.
    mem_b[0] = 8'd10;
    mem_b[1] = 8'd63;
    mem_b[2] = 8'd70;
    for (int k = 3; k < NPIX; k++) mem_b[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < NPIX; k++) begin
      int v;
      v = int'(mem_b[k]) * 4;
      if (v > 255) v = 255;
      expb_q.push_back(8'(v));
    end
    push_frame_a();
    chk_b = 1'b1;
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b1, 1'b0);
    chk("t6_first_scaled", 32'(data_b), 32'd40);
    run_until_empty(1'b0, 400, "t6");
    chk("t6_b_drained", 32'(expb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
